exc_pipe_stage: RTL and testbench

EXC_PIPE_STAGE -- requirements
Module: exc_pipe_stage

---
 rtl/exc_pipe_stage_pkg.sv | 20 ++
 rtl/exc_src_arbiter.sv | 28 ++
 rtl/exc_pipe_stage.sv | 199 +++++++++++++++++++
 tb/tb_exc_pipe_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pipe_stage_pkg.sv
// Shared CP0 definitions: ExcCode constants and helpers used by the
// exception pipeline stage and anything else that reasons about CP0 causes.
package exc_pipe_stage_pkg;

  localparam int EXC_W = 5;

  typedef logic [EXC_W-1:0] exccode_t;

  // MIPS ExcCode values written into Cause.ExcCode
  localparam exccode_t EXC_ADEL = 5'd4;   // address error, load/fetch
  localparam exccode_t EXC_ADES = 5'd5;   // address error, store
  localparam exccode_t EXC_SYS  = 5'd8;   // syscall
  localparam exccode_t EXC_BP   = 5'd9;   // breakpoint
  localparam exccode_t EXC_RI   = 5'd10;  // reserved instruction
  localparam exccode_t EXC_OV   = 5'd12;  // arithmetic overflow

  // A delay-slot instruction reports the PC of its branch, one word earlier
  localparam int DS_PC_OFFSET = 4;

endpackage

// File: rtl/exc_src_arbiter.sv
// Fixed-priority picker over the local exception sources of a stage:
// the lowest set request index wins. Purely combinational.
module exc_src_arbiter #(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [N_SRC-1:0] gnt_o,
  output logic             any_o
);

  logic found;

  // Walk upward from index 0 and grant the first request seen
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned, which would infer a latch.
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/exc_pipe_stage.sv
// Exception-merging pipeline stage. Folds locally detected exceptions into
// the upstream exception state, computes EPC, and registers the result
// behind a valid/ready handshake with one cycle of latency.
// Build option: define EXC_SKID_EN to add a one-entry skid buffer so that
// in_ready is a pure register output with no path from out_ready.
module exc_pipe_stage
  import exc_pipe_stage_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [PC_W-1:0]       in_badvaddr,
  input  logic [EXC_W-1:0]      in_exccode,
  input  logic                  in_exc,
  input  logic                  in_in_ds,
  input  logic                  in_eret,
  input  logic [N_SRC-1:0]      loc_exc,
  input  logic [EXC_W*N_SRC-1:0] loc_code,
  input  logic [PC_W*N_SRC-1:0] loc_badvaddr,
  input  logic [N_SRC-1:0]      loc_is_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [PC_W-1:0]       out_epc,
  output logic [PC_W-1:0]       out_badvaddr,
  output logic [EXC_W-1:0]      out_exccode,
  output logic                  out_exc,
  output logic                  out_in_ds,
  output logic                  out_eret,
  output logic                  exc_commit
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  epc;
    logic [PC_W-1:0]  badvaddr;
    logic [EXC_W-1:0] exccode;
    logic             exc;
    logic             in_ds;
    logic             eret;
  } entry_t;

  logic [N_SRC-1:0] loc_gnt;
  logic             loc_any;
  logic [EXC_W-1:0] sel_code;
  logic [PC_W-1:0]  sel_badvaddr;
  logic             sel_is_addr;

  entry_t entry_d;
  entry_t main_q, main_d;
  logic   main_valid_q, main_valid_d;
  logic   capture;
  logic   out_fire;

  exc_src_arbiter #(
    .N_SRC (N_SRC)
  ) u_arb (
    .req_i (loc_exc),
    .gnt_o (loc_gnt),
    .any_o (loc_any)
  );

  // Route the granted source's code/address through a one-hot AND-OR mux
  always_comb begin
    sel_code     = '0;
    sel_badvaddr = '0;
    sel_is_addr  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (loc_gnt[i]) begin
        sel_code     = loc_code[EXC_W*i +: EXC_W];
        sel_badvaddr = loc_badvaddr[PC_W*i +: PC_W];
        sel_is_addr  = loc_is_addr[i];
      end
    end
  end

  // Build the entry to capture: upstream exception outranks local sources
  always_comb begin
    entry_d.pc       = in_pc;
    entry_d.epc      = in_in_ds ? (in_pc - PC_W'(DS_PC_OFFSET)) : in_pc;
    entry_d.in_ds    = in_in_ds;
    entry_d.eret     = in_eret;
    entry_d.exc      = in_exc || loc_any;
    entry_d.exccode  = in_exccode;
    entry_d.badvaddr = in_badvaddr;
    if (!in_exc && loc_any) begin
      entry_d.exccode = sel_code;
      if (sel_is_addr) begin
        entry_d.badvaddr = sel_badvaddr;
      end
    end
  end

  assign capture  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

`ifdef EXC_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  // Registered ready: accept whenever the overflow slot is free
  assign in_ready = !skid_valid_q;

  // Main/skid occupancy; the skid entry always drains into main first
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (capture) begin
        main_d = entry_d;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (capture) begin
      if (main_valid_q) begin
        skid_d       = entry_d;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = entry_d;
        main_valid_d = 1'b1;
      end
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // Skid valid bit; reset outranks flush, which is folded into skid_valid_d
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
  end

  // Skid payload holds its value unless a capture selects it
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end
`else
  // Combinational ready: room now, or the held entry leaves this cycle
  assign in_ready = !main_valid_q || out_ready;

  // Single-register occupancy
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (capture) begin
      main_d       = entry_d;
      main_valid_d = 1'b1;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    if (flush) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  // Main valid bit; synchronous reset outranks flush and capture
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (reset) begin
      main_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
    end
  end

  // Main payload register
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; the valid bit qualifies it, which keeps reset fan-out to the control bits only.
    main_q <= main_d;
  end

  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_epc      = main_q.epc;
  assign out_badvaddr = main_q.badvaddr;
  assign out_exccode  = main_q.exccode;
  assign out_exc      = main_q.exc;
  assign out_in_ds    = main_q.in_ds;
  assign out_eret     = main_q.eret;
  assign exc_commit   = main_valid_q && out_ready && main_q.exc;

endmodule

// File: tb/tb_exc_pipe_stage.sv
// Scoreboard bench for exc_pipe_stage. Expected entries are computed from
// the driven inputs on every accepted transfer and compared against the
// head entry while it is presented downstream. Honors EXC_SKID_EN.
module tb_exc_pipe_stage;
  import exc_pipe_stage_pkg::*;

  localparam int N_SRC = 2;
  localparam int PC_W  = 32;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] bva;
    logic [4:0]      code;
    logic            exc;
    logic            ds;
    logic            eret;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [PC_W-1:0]       in_pc;
  logic [PC_W-1:0]       in_badvaddr;
  logic [4:0]            in_exccode;
  logic                  in_exc;
  logic                  in_in_ds;
  logic                  in_eret;
  logic [N_SRC-1:0]      loc_exc;
  logic [5*N_SRC-1:0]    loc_code;
  logic [PC_W*N_SRC-1:0] loc_badvaddr;
  logic [N_SRC-1:0]      loc_is_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_W-1:0]       out_pc;
  logic [PC_W-1:0]       out_epc;
  logic [PC_W-1:0]       out_badvaddr;
  logic [4:0]            out_exccode;
  logic                  out_exc;
  logic                  out_in_ds;
  logic                  out_eret;
  logic                  exc_commit;

  exp_t            sb[$];
  logic [PC_W-1:0] fired_pc[$];
  logic            last_acc;
  int              n_checks;
  int              n_errors;
  int              n_acc;

  exc_pipe_stage #(
    .N_SRC (N_SRC),
    .PC_W  (PC_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_badvaddr  (in_badvaddr),
    .in_exccode   (in_exccode),
    .in_exc       (in_exc),
    .in_in_ds     (in_in_ds),
    .in_eret      (in_eret),
    .loc_exc      (loc_exc),
    .loc_code     (loc_code),
    .loc_badvaddr (loc_badvaddr),
    .loc_is_addr  (loc_is_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_epc      (out_epc),
    .out_badvaddr (out_badvaddr),
    .out_exccode  (out_exccode),
    .out_exc      (out_exc),
    .out_in_ds    (out_in_ds),
    .out_eret     (out_eret),
    .exc_commit   (exc_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one captured entry, from the current inputs
  function automatic exp_t model();
    exp_t m;
    m.pc   = in_pc;
    m.epc  = in_in_ds ? in_pc - 32'd4 : in_pc;
    m.ds   = in_in_ds;
    m.eret = in_eret;
    m.exc  = in_exc;
    m.code = in_exccode;
    m.bva  = in_badvaddr;
    if (!in_exc) begin
      // descending scan: the last hit (lowest index) wins
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (loc_exc[i]) begin
          m.exc  = 1'b1;
          m.code = loc_code[5*i +: 5];
          m.bva  = loc_is_addr[i] ? loc_badvaddr[PC_W*i +: PC_W] : in_badvaddr;
        end
      end
    end
    return m;
  endfunction

  // One clock: sample/compare at the falling edge, then advance past the rising edge
  task automatic cycle();
    exp_t h;
    @(negedge clk);
    check("out_valid", out_valid, sb.size() != 0);
`ifdef EXC_SKID_EN
    check("in_ready", in_ready, sb.size() < 2);
`else
    check("in_ready", in_ready, (sb.size() == 0) || out_ready);
`endif
    check("exc_commit", exc_commit, (sb.size() != 0) ? (out_ready && sb[0].exc) : 1'b0);
    if (sb.size() != 0) begin
      h = sb[0];
      check("out_pc", out_pc, h.pc);
      check("out_epc", out_epc, h.epc);
      check("out_badvaddr", out_badvaddr, h.bva);
      check("out_exccode", out_exccode, h.code);
      check("out_exc", out_exc, h.exc);
      check("out_in_ds", out_in_ds, h.ds);
      check("out_eret", out_eret, h.eret);
      if (out_ready) begin
        fired_pc.push_back(h.pc);
        void'(sb.pop_front());
      end
    end
    last_acc = in_valid && in_ready && !flush && !reset;
    if (last_acc) sb.push_back(model());
    if (flush || reset) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_pc        = '0;
    in_badvaddr  = '0;
    in_exccode   = '0;
    in_exc       = 1'b0;
    in_in_ds     = 1'b0;
    in_eret      = 1'b0;
    loc_exc      = '0;
    loc_code     = '0;
    loc_badvaddr = '0;
    loc_is_addr  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_acc = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_exc_commit", exc_commit, 0);
    cycle();

    // Local RI in a delay slot: EPC backs up one word
    in_valid = 1'b1; in_pc = 32'hBFC0_0010; in_in_ds = 1'b1;
    loc_exc = 2'b01; loc_code[4:0] = EXC_RI;
    cycle();
    idle_inputs();
    check("r030_exc", out_exc, 1);
    check("r030_code", out_exccode, 10);
    check("r030_epc", out_epc, 32'hBFC0_000C);
    cycle();

    // Upstream exception overrides both local sources
    in_valid = 1'b1; in_pc = 32'h0000_1000; in_exc = 1'b1; in_exccode = EXC_ADEL;
    in_badvaddr = 32'h1003; loc_exc = 2'b11; loc_code = {EXC_OV, EXC_SYS};
    loc_is_addr = 2'b11; loc_badvaddr = {32'h5555_0000, 32'h6666_0000};
    cycle();
    idle_inputs();
    check("r031_code", out_exccode, 4);
    check("r031_bva", out_badvaddr, 32'h1003);
    cycle();

    // Address-type local source supplies its own badvaddr
    in_valid = 1'b1; in_pc = 32'h0000_2000; in_badvaddr = 32'h0000_0BAD;
    loc_exc = 2'b10; loc_code[9:5] = EXC_ADES; loc_is_addr = 2'b10;
    loc_badvaddr[63:32] = 32'h2002;
    cycle();
    idle_inputs();
    check("r032_code", out_exccode, 5);
    check("r032_bva", out_badvaddr, 32'h2002);
    cycle();

    // Both local sources, index 0 non-address; ERET kept alongside exception
    in_valid = 1'b1; in_pc = 32'h0040_0000; in_badvaddr = 32'h0000_0777; in_eret = 1'b1;
    loc_exc = 2'b11; loc_code = {EXC_ADEL, EXC_BP}; loc_is_addr = 2'b10;
    loc_badvaddr = {32'h9999_9999, 32'h8888_8888};
    cycle();
    idle_inputs();
    check("mix_code", out_exccode, 9);
    check("mix_bva", out_badvaddr, 32'h777);
    check("mix_eret", out_eret, 1);
    check("mix_exc", out_exc, 1);
    cycle();

    // EPC wraps modulo 2^PC_W
    in_valid = 1'b1; in_pc = 32'h0; in_in_ds = 1'b1;
    cycle();
    idle_inputs();
    check("wrap_epc", out_epc, 32'hFFFF_FFFC);
    check("wrap_noexc", out_exc, 0);
    cycle();

    // Random traffic with backpressure and occasional flush
    for (int k = 0; k < 300; k++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom() & 32'hFFFF_FFFC;
      in_badvaddr  = $urandom();
      in_exccode   = 5'($urandom_range(0, 31));
      in_exc       = ($urandom_range(0, 3) == 0);
      in_in_ds     = $urandom_range(0, 1) != 0;
      in_eret      = ($urandom_range(0, 7) == 0);
      loc_exc      = 2'($urandom_range(0, 3));
      loc_code     = 10'($urandom());
      loc_badvaddr = {$urandom(), $urandom()};
      loc_is_addr  = 2'($urandom_range(0, 3));
      out_ready    = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle_inputs();
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush with the stage full and a simultaneous capture attempt
    out_ready = 1'b0;
    in_valid = 1'b1; in_exc = 1'b1; in_exccode = EXC_SYS;
    for (int k = 0; k < 2; k++) begin
      in_pc = 32'h100 + 32'(k * 4);
      cycle();
    end
    in_pc = 32'h200; flush = 1'b1;
    cycle();
    flush = 1'b0; idle_inputs(); out_ready = 1'b1;
    check("r033_valid", out_valid, 0);
    check("r033_commit", exc_commit, 0);
    cycle();

    // Three PCs offered while stalled, then released; order must hold
    fired_pc.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'hA000 + 32'(n_acc * 32'h1000);
      cycle();
      if (last_acc) n_acc++;
    end
`ifdef EXC_SKID_EN
    check("r034_acc", n_acc, 2);
    check("r034_rdy", in_ready, 0);
`else
    check("r034_acc", n_acc, 1);
    check("r034_rdy", in_ready, 0);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 12 && fired_pc.size() < 3; k++) begin
      in_valid = (n_acc < 3);
      in_pc = 32'hA000 + 32'(n_acc * 32'h1000);
      cycle();
      if (last_acc) n_acc++;
    end
    in_valid = 1'b0;
    check("r034_count", fired_pc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("r034_order", (k < fired_pc.size()) ? fired_pc[k] : 32'hDEAD_DEAD,
            32'hA000 + 32'(k * 32'h1000));
    end

    // Reset while stalled and full
    idle_inputs();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = 32'h300;
    repeat (2) cycle();
    in_valid = 1'b0;
    cycle();
    check("r035_full", out_valid, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("r035_valid", out_valid, 0);
    check("r035_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();

    // Drain and confirm nothing outstanding
    for (int k = 0; k < 6; k++) cycle();
    check("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
